// File: rtl/store_pkg.sv
// Shared types for the narrowing store path: funct3 encodings, FSM states and store widths.
package store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_ERROR
   } store_state_t;

   typedef enum logic [1:0] {
      WID_B,
      WID_H,
      WID_W
   } store_width_t;

   function automatic store_width_t f3_to_width(input logic [2:0] f3);
      case (f3)
         F3_SB:   return WID_B;
         F3_SH:   return WID_H;
         default: return WID_W;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays the narrowed store data onto the old memory word.
module store_lane_merge
   import store_pkg::*;
(
   input  logic [31:0]  old_i,
   input  logic [31:0]  data_i,
   input  store_width_t width_i,
   input  logic [1:0]   off_i,
   output logic [31:0]  merged_o
);

   always_comb begin
      merged_o = old_i;
      case (width_i)
         WID_B: begin
            case (off_i)
               2'd0:    merged_o[7:0]   = data_i[7:0];
               2'd1:    merged_o[15:8]  = data_i[7:0];
               2'd2:    merged_o[23:16] = data_i[7:0];
               default: merged_o[31:24] = data_i[7:0];
            endcase
         end
         WID_H: begin
            if (off_i[1]) merged_o[31:16] = data_i[15:0];
            else          merged_o[15:0]  = data_i[15:0];
         end
         default: merged_o = data_i;
      endcase
   end

endmodule

// File: rtl/store_narrow_rmw.sv
// SB/SH/SW store path into a word-wide memory without byte enables (read-modify-write for sub-word).
// Optional build macro STORE_MISALIGN_TRAP_EN: misaligned SH/SW are rejected instead of force-aligned.
module store_narrow_rmw
   import store_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_data,
   input  logic [2:0]    req_funct3,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_en,
   input  logic [31:0]   mem_rdata,
   output logic          mem_wr_en,
   output logic [31:0]   mem_wdata,
   output logic          done,
   output logic          err
);

   store_state_t  state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    off_q, off_d;
   store_width_t  wid_q, wid_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   merged;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:AW+2];

   store_lane_merge u_merge (
      .old_i    (mem_rdata),
      .data_i   (data_q),
      .width_i  (wid_q),
      .off_i    (off_q),
      .merged_o (merged)
   );

   always_comb begin
      logic legal;
      logic trap;
      state_d = state_q;
      addr_d  = addr_q;
      off_d   = off_q;
      wid_d   = wid_q;
      data_d  = data_q;
      wdata_d = wdata_q;
      legal   = 1'b0;
      trap    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               legal  = (req_funct3 == F3_SB) || (req_funct3 == F3_SH) || (req_funct3 == F3_SW);
`ifdef STORE_MISALIGN_TRAP_EN
               trap   = ((req_funct3 == F3_SH) && req_addr[0]) ||
                        ((req_funct3 == F3_SW) && (req_addr[1:0] != 2'b00));
`else
               trap   = 1'b0;
`endif
               addr_d = req_addr[AW+1:2];
               data_d = req_data;
               wid_d  = f3_to_width(req_funct3);
               // Offsets are force-aligned to the access width; the trap build never uses the dropped bits.
               case (req_funct3)
                  F3_SB:   off_d = req_addr[1:0];
                  F3_SH:   off_d = {req_addr[1], 1'b0};
                  default: off_d = 2'b00;
               endcase
               if (!legal || trap) begin
                  state_d = S_ERROR;
               end else if (req_funct3 == F3_SW) begin
                  wdata_d = req_data;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ:  state_d = S_MERGE;
         S_MERGE: begin
            wdata_d = merged;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         off_q   <= 2'b00;
         wid_q   <= WID_W;
         data_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         wid_q   <= wid_d;
         data_q  <= data_d;
         wdata_q <= wdata_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign mem_rd_en = (state_q == S_READ);
   assign mem_wr_en = (state_q == S_WRITE);
   assign done      = (state_q == S_WRITE);
   assign err       = (state_q == S_ERROR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Randomized bench for store_narrow_rmw: per-cycle compare against a transaction-level store model.
module tb_store_narrow_rmw;

   localparam int AW = 10;
   localparam int NC = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_data = '0;
   logic [2:0]    req_funct3 = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [31:0]   mem_rdata = '0;
   logic          mem_wr_en;
   logic [31:0]   mem_wdata;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   store_narrow_rmw #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .done(done), .err(err)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int next_free = 0;

   bit            exp_rd [NC];
   bit            exp_wr [NC];
   bit            exp_err[NC];
   bit            exp_nr [NC];
   logic [AW-1:0] exp_ad [NC];
   logic [31:0]   exp_wd [NC];
   logic [31:0]   ref_mem[16];
   logic [31:0]   sim_mem[1024];

   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] last_wd = '0;
   bit          pl_we = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [31:0] pl_d = '0;

   // Memory model: one-cycle read latency, writes land at the strobe edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_we) sim_mem[pl_a] = pl_d;
      if (mem_rd_en) begin
         mem_rdata <= sim_mem[mem_addr];
         rd_cnt <= rd_cnt + 1;
      end
      if (mem_wr_en) begin
         sim_mem[mem_addr] = mem_wdata;
         last_wd <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d, input logic [31:0] old);
      int sh;
      logic [31:0] m;
      if (f3 == 3'b010) return d;
      if (f3 == 3'b000) begin
         sh = 8 * int'(a[1:0]);
         m  = 32'h0000_00FF << sh;
      end else begin
         sh = 16 * int'(a[1]);
         m  = 32'h0000_FFFF << sh;
      end
      return (old & ~m) | ((d << sh) & m);
   endfunction

   function automatic bit rejected(input logic [2:0] f3, input logic [31:0] a);
      if (f3 > 3'b010) return 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
      return ((f3 == 3'b001) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   // Records what the outputs must look like for the cycles following an accept at cycle c.
   task automatic model_accept(input int c, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int w;
      logic [31:0] nw;
      w = int'(a[5:2]);
      if (rejected(f3, a)) begin
         exp_err[c+1] = 1'b1;
         exp_nr[c+1]  = 1'b1;
         next_free    = c + 2;
      end else if (f3 == 3'b010) begin
         exp_wr[c+1] = 1'b1;
         exp_ad[c+1] = a[AW+1:2];
         exp_wd[c+1] = d;
         exp_nr[c+1] = 1'b1;
         ref_mem[w]  = d;
         next_free   = c + 2;
      end else begin
         nw = ref_word(f3, a, d, ref_mem[w]);
         exp_rd[c+1] = 1'b1;
         exp_ad[c+1] = a[AW+1:2];
         exp_wr[c+3] = 1'b1;
         exp_ad[c+3] = a[AW+1:2];
         exp_wd[c+3] = nw;
         for (int k = 1; k <= 3; k++) exp_nr[c+k] = 1'b1;
         ref_mem[w]  = nw;
         next_free   = c + 4;
      end
   endtask

   always @(negedge clk) begin
      int c;
      if (chk_en) begin
         c = cyc;
         chk("req_ready", {31'd0, req_ready}, {31'd0, !exp_nr[c]});
         chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_rd[c]});
         chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_wr[c]});
         chk("done",      {31'd0, done},      {31'd0, exp_wr[c]});
         chk("err",       {31'd0, err},       {31'd0, exp_err[c]});
         if (exp_rd[c] || exp_wr[c]) chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_ad[c]});
         if (exp_wr[c]) chk("mem_wdata", mem_wdata, exp_wd[c]);
      end
   end

   task automatic preload(input int w, input logic [31:0] v);
      @(negedge clk);
      pl_we = 1'b1; pl_a = AW'(w); pl_d = v;
      ref_mem[w] = v;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      while (cyc < next_free) @(negedge clk);
      req_funct3 = f3; req_addr = a; req_data = d; req_valid = 1'b1;
      model_accept(cyc, f3, a, d);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic settle();
      while (cyc < next_free) @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int r0, w0, e0;
      logic [2:0] f3;
      logic [31:0] a, d;
      bit v;
      int rsel;

      for (int w = 0; w < 16; w++) preload(w, $urandom);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      chk("rst_addr",  {22'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      next_free = cyc;
      chk_en = 1'b1;

      chk("model_sb", ref_word(3'b000, 32'h5, 32'h1234_56AB, 32'h1122_3344), 32'h1122_AB44);
      chk("model_sh", ref_word(3'b001, 32'h2, 32'hFFFF_8001, 32'hAAAA_BBBB), 32'h8001_BBBB);

      r0 = rd_cnt;
      issue(3'b010, 32'h0000_0008, 32'hDEAD_BEEF);
      settle();
      chk("sw_literal", last_wd, 32'hDEAD_BEEF);
      chk("sw_no_read", rd_cnt, r0);

      preload(1, 32'h1122_3344);
      issue(3'b000, 32'h0000_0005, 32'h1234_56AB);
      settle();
      chk("sb_literal", last_wd, 32'h1122_AB44);

      preload(0, 32'hAAAA_BBBB);
      issue(3'b001, 32'h0000_0002, 32'hFFFF_8001);
      settle();
      chk("sh_literal", last_wd, 32'h8001_BBBB);

      w0 = wr_cnt; e0 = err_cnt;
      issue(3'b001, 32'h0000_0003, 32'h0000_5A5A);
      settle();
`ifdef STORE_MISALIGN_TRAP_EN
      chk("sh_mis_err", err_cnt, e0 + 1);
      chk("sh_mis_nowr", wr_cnt, w0);
`else
      chk("sh_mis_literal", last_wd, 32'h5A5A_BBBB);
      chk("sh_mis_noerr", err_cnt, e0);
`endif

      w0 = wr_cnt; e0 = err_cnt; r0 = rd_cnt;
      issue(3'b011, 32'h0000_0004, 32'hCAFE_F00D);
      settle();
      chk("f3_011_err", err_cnt, e0 + 1);
      chk("f3_011_nowr", wr_cnt, w0);
      chk("f3_011_nord", rd_cnt, r0);

      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         rsel = $urandom_range(0, 9);
         f3 = (rsel < 3) ? 3'b000 : (rsel < 6) ? 3'b001 : (rsel < 9) ? 3'b010 : 3'($urandom_range(3, 7));
         a = $urandom & 32'hFFFF_F03F;
         d = $urandom;
         v = ($urandom_range(0, 3) != 0);
         req_funct3 = f3; req_addr = a; req_data = d; req_valid = v;
         if (v && (cyc >= next_free)) model_accept(cyc, f3, a, d);
      end
      @(negedge clk);
      req_valid = 1'b0;
      settle();
      for (int w = 0; w < 16; w++) chk("final_mem", sim_mem[w], ref_mem[w]);

      // Reset during MERGE of an SB must abort without a write.
      chk_en = 1'b0;
      preload(3, 32'h5566_7788);
      w0 = wr_cnt;
      @(negedge clk);
      req_funct3 = 3'b000; req_addr = 32'h0000_000C; req_data = 32'h0000_00AA; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_rd_en", {31'd0, mem_rd_en}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_write", wr_cnt, w0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_word_kept", sim_mem[3], 32'h5566_7788);
      req_funct3 = 3'b010; req_addr = 32'h0000_000C; req_data = 32'h0BAD_F00D; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("post_sw_done", {31'd0, done}, 32'd1);
      chk("post_sw_wr", {31'd0, mem_wr_en}, 32'd1);
      chk("post_sw_addr", {22'd0, mem_addr}, 32'd3);
      chk("post_sw_wdata", mem_wdata, 32'h0BAD_F00D);
      @(negedge clk);
      chk("post_sw_ready", {31'd0, req_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store path of the single-cycle RISC-V core: the narrowing counterpart to load-side sign extension. Accepts SB/SH/SW requests with a byte address and 32-bit register data, truncates the data to the store width, and writes it into a word-wide data memory with no byte enables. Sub-word stores use a read-modify-write sequence; full-word stores write directly.

## Interface
- `AW`, default 10: word-address width of the data memory.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_addr`  in  32  byte address; bits [AW+1:2] select the word.
- `req_data`  in  32  rs2 value; only the low 8 or 16 bits are used for SB/SH.
- `req_funct3`  in  3  store width: 000 SB, 001 SH, 010 SW; any other value is illegal.
- `mem_addr`  out  AW  word address, held stable from accept until done.
- `mem_rd_en`  out  1  one-cycle read strobe; `mem_rdata` is valid in the following cycle.
- `mem_rdata`  in  32  read data.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_wdata`  out  32  write data, valid while `mem_wr_en` is high.
- `done`  out  1  one-cycle pulse when the store completes, concurrent with `mem_wr_en`.
- `err`  out  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, READ, MERGE, WRITE, ERROR.
- IDLE: `req_ready`=1. On accept, register the word address, byte offset `addr[1:0]`, width, and `req_data`.
  - Legal SW goes to WRITE.
  - Legal SB or SH goes to READ.
  - A misaligned or illegal request goes to ERROR (see Configuration).
- READ: `mem_rd_en`=1, then go to MERGE.
- MERGE: capture `mem_rdata` and replace only the target lanes, then go to WRITE.
  - SB writes `data[7:0]` into byte `addr[1:0]`.
  - SH writes `data[15:0]` into halfword `addr[1]`.
  - All other bits equal `mem_rdata`.
- WRITE: `mem_wr_en`=1 and `done`=1. `mem_wdata` is the merged word for SB/SH or the full `req_data` for SW. Then go to IDLE.
- ERROR: `err`=1, no memory strobe, then go to IDLE.
- Illegal `funct3` always goes to ERROR, regardless of configuration.
- Reset values: state IDLE, `mem_rd_en`=0, `mem_wr_en`=0, `done`=0, `err`=0, `mem_addr`=0, `mem_wdata`=0. `req_ready`=1 is derived from IDLE.
- Reset asserted mid-sequence aborts the store: no write is issued and the state returns to IDLE.
- `req_valid` in any non-IDLE state is ignored; the request is not accepted.

## Timing
- Accept at cycle N.
- SW: write and `done` at N+1; next accept possible at N+2.
- SB/SH: `mem_rd_en` at N+1, data capture at N+2, write and `done` at N+3; next accept possible at N+4.
- Error: `err` at N+1; next accept possible at N+2.
- The memory must return `mem_rdata` exactly one cycle after `mem_rd_en`; no wait states.
- All outputs are registered or decoded from the state only; no combinational path from `req_*` to `mem_*`.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - SH with `addr[0]`=1 goes to ERROR.
  - SW with `addr[1:0]`≠0 goes to ERROR.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Misaligned offsets are force-aligned: SH clears `addr[0]`, SW clears `addr[1:0]`.
  - The store proceeds normally and `err` stays 0 for legal `funct3`.

## Structure
- Package `store_pkg` holds:
  - `funct3` constants `F3_SB`, `F3_SH`, `F3_SW`.
  - The state enum.
  - The `store_width_t` typedef.
- Sub-module `store_lane_merge` is combinational. Inputs: old word, data, width, offset. Output: merged word. It is instantiated once, feeding the MERGE capture register.

## Test plan
- SW, `addr`=0x0000_0008, `data`=0xDEAD_BEEF → `mem_addr`=2, write 0xDEADBEEF at N+1 with `done`, no `mem_rd_en`.
- SB, `addr`=0x0000_0005, `data`=0x1234_56AB, old word 0x1122_3344 → `mem_rd_en` at N+1, write 0x1122_AB44 at N+3, `done` at N+3.
- SH, `addr`=0x0000_0002, `data`=0xFFFF_8001, old word 0xAAAA_BBBB → write 0x8001_BBBB.
- SH, `addr`=0x0000_0003:
  - With `STORE_MISALIGN_TRAP_EN`: `err` at N+1, no strobes.
  - Without it: write to the upper halfword.
- `funct3`=011 → `err` at N+1, no memory access, in both builds.
- `rst_n` low during MERGE of an SB → no `mem_wr_en` ever, `req_ready`=1 after release, next SW completes normally.
